// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// word/strobe widths and the latched request payload.
package riscv_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit storage with byte-strobed synchronous write, registered read
// and a synchronous clear of every word and of the read register.
module dmem_array
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_clear,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic              i_rclr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Clear wins over any access; a read load wins over a read clear.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
          if (i_wstrb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
      if (i_re) begin
        r_rdata <= r_mem[i_addr];
      end else if (i_rclr) begin
        r_rdata <= '0;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port with configurable wait states.
// Optional access-fault checking is enabled by defining DMEM_ERR_EN.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  localparam int unsigned AW = $clog2(MEMORY_SIZE);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  req_t              r_req;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic              w_accept;
  logic              w_commit;
  logic              w_rsp_done;
  logic              w_fault;
  logic [AW-1:0]     w_idx;
  logic              w_mem_we;
  logic              w_mem_re;
  logic              w_mem_rclr;
  logic [WORD_W-1:0] w_rdata;
  logic              w_unused_addr;

  assign w_idx = r_req.addr[2 +: AW];

  // Address bits outside the word index only matter to the fault check.
  assign w_unused_addr = ^{r_req.addr[1:0], r_req.addr[WORD_W-1:AW+2]};

`ifdef DMEM_ERR_EN
  assign w_fault = (r_req.addr[1:0] != 2'b00) || (r_req.addr[WORD_W-1:AW+2] != '0);
`else
  assign w_fault = 1'b0;
`endif

  // Next-state and handshake strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_W'(WAIT_STATES);
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_next_state = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_RESP);
      if (w_accept) begin
        r_req <= '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
      end
      if (w_commit) begin
        r_rsp_error <= w_fault;
      end else if (w_rsp_done) begin
        r_rsp_error <= 1'b0;
      end
    end
  end

  // Memory touches happen only on the commit edge; faulting or store responses carry zero data.
  assign w_mem_we   = w_commit && r_req.write && !w_fault;
  assign w_mem_re   = w_commit && !r_req.write && !w_fault;
  assign w_mem_rclr = (w_commit && (r_req.write || w_fault)) || w_rsp_done;

  dmem_array #(
    .DEPTH (MEMORY_SIZE),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_clear (!reset),
    .i_addr  (w_idx),
    .i_we    (w_mem_we),
    .i_wstrb (r_req.wstrb),
    .i_wdata (r_req.wdata),
    .i_re    (w_mem_re),
    .i_rclr  (w_mem_rclr),
    .o_rdata (w_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = w_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (MEMORY_SIZE=256, WAIT_STATES=2);
// expectations follow DMEM_ERR_EN when it is defined for the build.
module tb_data_mem_responder;

  localparam int unsigned WS = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [256];
  logic [32:0] sb_q [$];

  data_mem_responder #(.MEMORY_SIZE(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference model: returns {error, rdata} and updates the model memory.
  function automatic logic [32:0] model_txn(input logic wr, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [3:0] st);
    logic       fault;
    logic [7:0] idx;
    fault = ERR_EN && ((a[1:0] != 2'b00) || (a >= 32'h400));
    idx   = a[9:2];
    if (wr) begin
      if (!fault)
        for (int b = 0; b < 4; b++)
          if (st[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      return {fault, 32'h0};
    end
    return {fault, fault ? 32'h0 : model_mem[idx]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
  endtask

  // Presents a request when req_ready is seen; returns right after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input bit track);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
    @(posedge clk);
    if (track) sb_q.push_back(model_txn(wr, a, wd, st));
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
  endtask

  // Waits for the response, holds rsp_ready low for 'hold' cycles, then handshakes.
  task automatic collect(input int hold, output logic [31:0] rd, output logic er,
                         output int lat, output bit stable, output bit idle);
    lat = 0; stable = 1'b1; idle = 1'b0; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = i; break; end
      if (req_ready !== 1'b0) stable = 1'b0;
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      return;
    end
    rd = rsp_rdata; er = rsp_error;
    if (req_ready !== 1'b0) stable = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_error !== er || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    idle = (req_ready === 1'b1) && (rsp_valid === 1'b0) &&
           (rsp_rdata === 32'h0) && (rsp_error === 1'b0);
  endtask

  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int hold,
                     output logic [31:0] rd, output logic er, output int lat,
                     output bit stable, output bit idle, output logic [32:0] exp);
    issue(wr, a, wd, st, 1'b1);
    collect(hold, rd, er, lat, stable, idle);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 33'bx;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b rdata=%h required all 0",
               req_ready, rsp_valid, rsp_error, rsp_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_full_store_load();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || lat != int'(WS) + 2) begin
      n_bad++; $display("FAIL store_full: rsp=%h lat=%0d required %h lat=%0d", {er, rd}, lat, e, WS + 2);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || lat != int'(WS) + 2 || !id) begin
      n_bad++; $display("FAIL load_full: rsp=%h lat=%0d idle=%b required %h lat=%0d", {er, rd}, lat, id, e, WS + 2);
    end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat, st, id, e);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || rd !== 32'hDEADBEAA) begin
      n_bad++; $display("FAIL byte_strobe: rdata=%h required %h", rd, e[31:0]);
    end
    txn(1'b1, 32'h10, 32'h12345678, 4'b0000, 0, rd, er, lat, st, id, e);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e) begin
      n_bad++; $display("FAIL zero_strobe: rdata=%h required %h", rd, e[31:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    txn(1'b1, 32'h20, 32'hA5A5_5A5A, 4'b1010, 0, rd, er, lat, st, id, e);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e) begin
      n_bad++; $display("FAIL bp_data: rsp=%h required %h", {er, rd}, e);
    end
    n_cmp++;
    if (!st || !id) begin
      n_bad++; $display("FAIL bp_stable: stable=%b idle_after=%b required 1 1", st, id);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    txn(1'b1, 32'h0,   32'h11223344, 4'hF, 0, rd, er, lat, st, id, e);
    txn(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, id, e);
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || rd !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL last_word: rsp=%h required %h", {er, rd}, e);
    end
    txn(1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || lat != int'(WS) + 2 || !id) begin
      n_bad++; $display("FAIL out_of_range: rsp=%h lat=%0d idle=%b required %h", {er, rd}, lat, id, e);
    end
  endtask

  task automatic test_misaligned_store();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    txn(1'b1, 32'h12, 32'h00000055, 4'hF, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e) begin
      n_bad++; $display("FAIL misaligned_store: rsp=%h required %h", {er, rd}, e);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e) begin
      n_bad++; $display("FAIL misaligned_effect: rsp=%h required %h", {er, rd}, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, d;
      a = {22'h0, 8'(8'h40 + k), 2'b00};
      d = $urandom;
      txn(1'b1, a, d, 4'($urandom), 0, rd, er, lat, st, id, e);
      txn(1'b0, a, 32'h0, 4'h0, k, rd, er, lat, st, id, e);
      n_cmp++;
      if ({er, rd} !== e || !st || !id) begin
        n_bad++; $display("FAIL b2b_%0d: rsp=%h stable=%b idle=%b required %h", k, {er, rd}, st, id, e);
      end
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd; logic er; int lat; bit st, id; logic [32:0] e;
    issue(1'b1, 32'h8, 32'hFEEDFACE, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_txn: vld=%b rdy=%b required 0 0", rsp_valid, req_ready);
    end
    reset = 1'b1;
    model_clear();
    txn(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, st, id, e);
    n_cmp++;
    if ({er, rd} !== e || rd !== 32'h0) begin
      n_bad++; $display("FAIL dropped_store: rdata=%h required %h", rd, e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_store_load();
    test_byte_strobe();
    test_backpressure();
    test_boundary();
    test_misaligned_store();
    test_back_to_back();
    test_reset_mid_txn();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover: size=%0d required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
